// File: rtl/ucode_pkg.sv
// Shared definitions for the RAM-programmable microcode sequencer:
// sequencer bit offsets, control-word type and the datapath strobe map.
package ucode_pkg;

  // Sequencer bits sit at the top of the control word; each offset is
  // subtracted from CW to get the bit index (INC is bit CW-1, and so on).
  localparam int SEQ_INC_OFS  = 1;
  localparam int SEQ_RST_OFS  = 2;
  localparam int SEQ_COND_OFS = 3;
  localparam int SEQ_SUB_OFS  = 4;
  localparam int SEQ_WAIT_OFS = 5;
  localparam int SEQ_BITS     = 5;

  // Default control-word width used across the RV32 datapath.
  localparam int CW_DEFAULT = 32;

  typedef logic [CW_DEFAULT-1:0] ucode_word_t;

  // RV32 datapath strobes: each value is the bit index on the ctrl bus.
  typedef enum logic [4:0] {
    STB_PC_WE      = 5'd0,
    STB_IR_WE      = 5'd1,
    STB_REG_WE     = 5'd2,
    STB_MEM_RD     = 5'd3,
    STB_MEM_WR     = 5'd4,
    STB_ALU_SRC_A  = 5'd5,
    STB_ALU_SRC_B  = 5'd6,
    STB_PC_SRC     = 5'd7,
    STB_MEM_TO_REG = 5'd8,
    STB_CSR_WE     = 5'd9
  } dp_strobe_e;

  // Absolute bit index of a sequencer bit for a given control-word width.
  function automatic int seq_bit(input int cw, input int ofs);
    return cw - ofs;
  endfunction

endpackage

// File: rtl/ucode_table.sv
// Microcode storage: entries x steps array of control words with a
// synchronous write port and an asynchronous read port. Out-of-range
// indices neither write nor read (reads return zero).
module ucode_table #(
  parameter int ENTRIES = 32,
  parameter int STEPS   = 8,
  parameter int WIDTH   = 32,
  parameter int IW      = 5,
  parameter int SW      = 3
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IW-1:0]    wr_idx_i,
  input  logic [SW-1:0]    wr_step_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [IW-1:0]    rd_idx_i,
  input  logic [SW-1:0]    rd_step_i,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam logic [IW:0] IDX_LIMIT  = (IW+1)'(ENTRIES);
  localparam logic [SW:0] STEP_LIMIT = (SW+1)'(STEPS);

  logic [WIDTH-1:0] mem_q [ENTRIES][STEPS];

  logic wr_ok;
  logic rd_ok;

  assign wr_ok = ({1'b0, wr_idx_i} < IDX_LIMIT) && ({1'b0, wr_step_i} < STEP_LIMIT);
  assign rd_ok = ({1'b0, rd_idx_i} < IDX_LIMIT) && ({1'b0, rd_step_i} < STEP_LIMIT);

  // Table write; no reset so contents survive a sequencer reset.
  always_ff @(posedge clk) begin
    if (we_i && wr_ok) begin
      mem_q[wr_idx_i][wr_step_i] <= wr_data_i;
    end
  end

  // Asynchronous read, zero for indices outside the table.
  always_comb begin
    rd_data_o = '0;
    if (rd_ok) begin
      rd_data_o = mem_q[rd_idx_i][rd_step_i];
    end
  end

endmodule

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: looks up the control word for (opcode, step),
// merges the func3 sub-table on SUB steps, and advances the step with
// WAIT / COND / RST / INC semantics. Also owns instret and cycle counters.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int CW    = 32,
  parameter int NOPC  = 32,
  parameter int NSTEP = 8,
  parameter int NSUB  = 8,
  localparam int OW   = $clog2(NOPC),
  localparam int SW   = $clog2(NSTEP),
  localparam int UW   = $clog2(NSUB)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [OW-1:0] opcode,
  input  logic [UW-1:0] subop,
  input  logic          cond,
  input  logic          mem_ready,
  input  logic          trap,
  input  logic          prog_we,
  input  logic          prog_sub,
  input  logic [OW-1:0] prog_index,
  input  logic [SW-1:0] prog_step,
  input  logic [CW-1:0] prog_data,
  output logic [CW-6:0] ctrl,
  output logic [SW-1:0] step,
  output logic          cond_skip,
  output logic          retire,
  output logic          seq_err,
  output logic [63:0]   instret,
  output logic [63:0]   cycles
);

  localparam int B_INC  = seq_bit(CW, SEQ_INC_OFS);
  localparam int B_RST  = seq_bit(CW, SEQ_RST_OFS);
  localparam int B_COND = seq_bit(CW, SEQ_COND_OFS);
  localparam int B_SUB  = seq_bit(CW, SEQ_SUB_OFS);
  localparam int B_WAIT = seq_bit(CW, SEQ_WAIT_OFS);

  localparam logic [SW-1:0] LAST_STEP = SW'(NSTEP - 1);

  logic [CW-1:0] prim_word;
  logic [CW-1:0] sub_word;
  logic [CW-1:0] word;

  logic [SW-1:0] step_q, step_d;
  logic          retire_q, retire_d;
  logic          seq_err_q, seq_err_d;
  logic [63:0]   instret_q, instret_d;
  logic [63:0]   cycles_q, cycles_d;
  logic          advance;

  ucode_table #(
    .ENTRIES(NOPC), .STEPS(NSTEP), .WIDTH(CW), .IW(OW), .SW(SW)
  ) u_prim (
    .clk       (clk),
    .we_i      (prog_we & ~prog_sub),
    .wr_idx_i  (prog_index),
    .wr_step_i (prog_step),
    .wr_data_i (prog_data),
    .rd_idx_i  (opcode),
    .rd_step_i (step_q),
    .rd_data_o (prim_word)
  );

  ucode_table #(
    .ENTRIES(NSUB), .STEPS(NSTEP), .WIDTH(CW), .IW(UW), .SW(SW)
  ) u_sub (
    .clk       (clk),
    .we_i      (prog_we & prog_sub),
    .wr_idx_i  (prog_index[UW-1:0]),
    .wr_step_i (prog_step),
    .wr_data_i (prog_data),
    .rd_idx_i  (subop),
    .rd_step_i (step_q),
    .rd_data_o (sub_word)
  );

  // Effective control word: sub-table word is OR-merged on SUB steps.
  always_comb begin
    word = prim_word;
    if (prim_word[B_SUB]) begin
      word = prim_word | sub_word;
    end
  end

  // Next-step FSM: trap > WAIT stall > COND > RST > INC > hold.
  always_comb begin
    step_d    = step_q;
    retire_d  = 1'b0;
    seq_err_d = seq_err_q;
    advance   = 1'b0;
    if (trap) begin
      step_d = '0;
    end else if (word[B_WAIT] && !mem_ready) begin
      step_d = step_q;
    end else if (word[B_COND]) begin
      if (cond) begin
        advance = 1'b1;
      end else begin
        step_d   = '0;
        retire_d = 1'b1;
      end
    end else if (word[B_RST]) begin
      step_d   = '0;
      retire_d = 1'b1;
    end else if (word[B_INC]) begin
      advance = 1'b1;
    end
    // Advancing past the last step is a microcode bug: wrap and flag it.
    if (advance) begin
      if (step_q == LAST_STEP) begin
        step_d    = '0;
        seq_err_d = 1'b1;
      end else begin
        step_d = step_q + SW'(1);
      end
    end
    instret_d = instret_q + {63'd0, retire_d};
    cycles_d  = cycles_q + 64'd1;
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_q    <= '0;
      retire_q  <= 1'b0;
      seq_err_q <= 1'b0;
      instret_q <= '0;
      cycles_q  <= '0;
    end else begin
      step_q    <= step_d;
      retire_q  <= retire_d;
      seq_err_q <= seq_err_d;
      instret_q <= instret_d;
      cycles_q  <= cycles_d;
    end
  end

  assign ctrl      = word[CW-6:0];
  assign step      = step_q;
  assign cond_skip = word[B_COND] & ~cond & ~trap;
  assign retire    = retire_q;
  assign seq_err   = seq_err_q;
  assign instret   = instret_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Bench for ucode_sequencer: programs small microcode routines and checks
// step sequencing, stalls, traps, overflow, sub-table merge and counters.
// Retire events are scoreboarded against the expected instret value.
module tb_ucode_sequencer;

  localparam int CW    = 32;
  localparam int NOPC  = 24;
  localparam int NSTEP = 4;
  localparam int NSUB  = 8;
  localparam int OW    = 5;
  localparam int SW    = 2;
  localparam int UW    = 3;

  localparam logic [31:0] INC  = 32'h8000_0000;
  localparam logic [31:0] RST  = 32'h4000_0000;
  localparam logic [31:0] COND = 32'h2000_0000;
  localparam logic [31:0] SUB  = 32'h1000_0000;
  localparam logic [31:0] WAIT = 32'h0800_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [OW-1:0] opcode = '0;
  logic [UW-1:0] subop = '0;
  logic          cond = 1'b0;
  logic          mem_ready = 1'b0;
  logic          trap = 1'b0;
  logic          prog_we = 1'b0;
  logic          prog_sub = 1'b0;
  logic [OW-1:0] prog_index = '0;
  logic [SW-1:0] prog_step = '0;
  logic [CW-1:0] prog_data = '0;
  logic [CW-6:0] ctrl;
  logic [SW-1:0] step;
  logic          cond_skip;
  logic          retire;
  logic          seq_err;
  logic [63:0]   instret;
  logic [63:0]   cycles;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  ucode_sequencer #(.CW(CW), .NOPC(NOPC), .NSTEP(NSTEP), .NSUB(NSUB)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .subop      (subop),
    .cond       (cond),
    .mem_ready  (mem_ready),
    .trap       (trap),
    .prog_we    (prog_we),
    .prog_sub   (prog_sub),
    .prog_index (prog_index),
    .prog_step  (prog_step),
    .prog_data  (prog_data),
    .ctrl       (ctrl),
    .step       (step),
    .cond_skip  (cond_skip),
    .retire     (retire),
    .seq_err    (seq_err),
    .instret    (instret),
    .cycles     (cycles)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic sub, input int idx, input int stp, input logic [31:0] data);
    prog_sub   = sub;
    prog_index = OW'(idx);
    prog_step  = SW'(stp);
    prog_data  = data;
    prog_we    = 1'b1;
    tick();
    prog_we    = 1'b0;
  endtask

  // Scoreboard: every retire pulse must match the next expected instret.
  always begin
    @(posedge clk);
    #2;
    if (retire === 1'b1) begin
      if (exp_q.size() == 0) check("retire_unexpected", {63'd0, retire}, 64'd0);
      else check("retire_instret", instret, exp_q.pop_front());
    end
  end

  initial begin
    // Reset held while the tables are cleared.
    tick();
    tick();
    check("rst_step", {62'd0, step}, 64'd0);
    check("rst_cycles", cycles, 64'd0);
    for (int i = 0; i < NOPC; i++)
      for (int s = 0; s < NSTEP; s++) prog(1'b0, i, s, 32'd0);
    for (int i = 0; i < NSUB; i++)
      for (int s = 0; s < NSTEP; s++) prog(1'b1, i, s, 32'd0);
    check("rst_retire", {63'd0, retire}, 64'd0);
    check("rst_seq_err", {63'd0, seq_err}, 64'd0);
    check("rst_instret", instret, 64'd0);
    reset = 1'b0;
    repeat (5) tick();
    check("cycles_run", cycles, 64'd5);
    check("zero_stall_step", {62'd0, step}, 64'd0);

    // Two-step op: INC|1 then RST|2.
    prog(1'b0, 5, 0, INC | 32'h1);
    prog(1'b0, 5, 1, RST | 32'h2);
    opcode = 5'd5;
    #1;
    check("op5_ctrl0", {37'd0, ctrl}, 64'h1);
    tick();
    check("op5_step1", {62'd0, step}, 64'd1);
    check("op5_ctrl1", {37'd0, ctrl}, 64'h2);
    exp_q.push_back(64'd1);
    tick();
    opcode = 5'd0;
    check("op5_step_ret", {62'd0, step}, 64'd0);
    check("op5_retire", {63'd0, retire}, 64'd1);
    tick();
    check("op5_retire_once", {63'd0, retire}, 64'd0);

    // Branch op with COND at step 2, taken then not taken.
    prog(1'b0, 7, 0, INC);
    prog(1'b0, 7, 1, INC);
    prog(1'b0, 7, 2, COND | 32'h8);
    prog(1'b0, 7, 3, RST | 32'h3);
    opcode = 5'd7;
    cond = 1'b1;
    tick();
    tick();
    check("br_ctrl", {37'd0, ctrl}, 64'h8);
    check("br_taken_skip", {63'd0, cond_skip}, 64'd0);
    tick();
    check("br_taken_step", {62'd0, step}, 64'd3);
    exp_q.push_back(64'd2);
    tick();
    cond = 1'b0;
    #1;
    check("br_step0_skip", {63'd0, cond_skip}, 64'd0);
    tick();
    tick();
    check("br_nt_step", {62'd0, step}, 64'd2);
    check("br_nt_skip", {63'd0, cond_skip}, 64'd1);
    exp_q.push_back(64'd3);
    tick();
    opcode = 5'd0;
    check("br_nt_ret_step", {62'd0, step}, 64'd0);
    check("br_nt_retire", {63'd0, retire}, 64'd1);

    // WAIT|RST at step 1 stalls until mem_ready.
    prog(1'b0, 9, 0, INC);
    prog(1'b0, 9, 1, WAIT | RST | 32'h5);
    opcode = 5'd9;
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_hold_step", {62'd0, step}, 64'd1);
      check("wait_no_retire", {63'd0, retire}, 64'd0);
    end
    mem_ready = 1'b1;
    exp_q.push_back(64'd4);
    tick();
    opcode = 5'd0;
    mem_ready = 1'b0;
    check("wait_retire", {63'd0, retire}, 64'd1);

    // RST wins over simultaneous INC.
    prog(1'b0, 17, 0, INC | RST | 32'h7);
    opcode = 5'd17;
    exp_q.push_back(64'd5);
    tick();
    opcode = 5'd0;
    check("rst_inc_step", {62'd0, step}, 64'd0);
    check("rst_inc_retire", {63'd0, retire}, 64'd1);

    // Trap wins over a WAIT stall.
    opcode = 5'd9;
    tick();
    trap = 1'b1;
    tick();
    trap = 1'b0;
    opcode = 5'd0;
    check("trap_wait_step", {62'd0, step}, 64'd0);
    check("trap_wait_retire", {63'd0, retire}, 64'd0);

    // Trap at step 2 of a 4-step op.
    prog(1'b0, 11, 0, INC);
    prog(1'b0, 11, 1, INC);
    prog(1'b0, 11, 2, INC);
    prog(1'b0, 11, 3, RST);
    opcode = 5'd11;
    tick();
    tick();
    check("trap_pre_step", {62'd0, step}, 64'd2);
    trap = 1'b1;
    tick();
    trap = 1'b0;
    opcode = 5'd0;
    check("trap_step", {62'd0, step}, 64'd0);
    check("trap_retire", {63'd0, retire}, 64'd0);
    check("trap_instret", instret, 64'd5);

    // INC at the last step overflows.
    for (int s = 0; s < NSTEP; s++) prog(1'b0, 13, s, INC);
    opcode = 5'd13;
    repeat (3) tick();
    check("ovf_pre_step", {62'd0, step}, 64'd3);
    check("ovf_pre_err", {63'd0, seq_err}, 64'd0);
    tick();
    opcode = 5'd0;
    check("ovf_step", {62'd0, step}, 64'd0);
    check("ovf_err", {63'd0, seq_err}, 64'd1);
    check("ovf_retire", {63'd0, retire}, 64'd0);
    tick();
    check("ovf_err_sticky", {63'd0, seq_err}, 64'd1);

    // SUB merge and live sub-table overwrite.
    prog(1'b0, 15, 0, INC);
    prog(1'b0, 15, 1, SUB | 32'h10);
    prog(1'b1, 3, 1, 32'h4);
    subop = 3'd3;
    opcode = 5'd15;
    tick();
    check("sub_step", {62'd0, step}, 64'd1);
    check("sub_ctrl", {37'd0, ctrl}, 64'h14);
    prog(1'b1, 3, 1, 32'h20);
    check("sub_ctrl_new", {37'd0, ctrl}, 64'h30);
    subop = 3'd2;
    #1;
    check("sub_other", {37'd0, ctrl}, 64'h10);

    // Reset mid-instruction: state clears, tables kept.
    reset = 1'b1;
    tick();
    check("rst2_step", {62'd0, step}, 64'd0);
    check("rst2_err", {63'd0, seq_err}, 64'd0);
    check("rst2_instret", instret, 64'd0);
    check("rst2_cycles", cycles, 64'd0);
    opcode = 5'd5;
    #1;
    check("rst2_table_kept", {37'd0, ctrl}, 64'h1);

    // Out-of-range opcode neither writes nor reads.
    prog(1'b0, 30, 0, INC | 32'hFF);
    opcode = 5'd30;
    #1;
    check("oor_ctrl", {37'd0, ctrl}, 64'h0);
    opcode = 5'd23;
    #1;
    check("last_entry_ctrl", {37'd0, ctrl}, 64'h0);

    tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
